// File: rtl/aes_inv_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES inverse cipher.
// Byte layout everywhere is row-major: state[r][c] = bits [8*(4r+c) +: 8].
package aes_inv_pkg;

    localparam int AES_BLK_W      = 128;
    localparam int AES_MAX_ROUNDS = 14;

    typedef logic [AES_BLK_W-1:0] aes_state_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} inv_fsm_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as SubBytes requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

endpackage

// File: rtl/aes_inv_round_dp.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// first selects the key-only whitening round, last skips InvMixColumns.
module aes_inv_round_dp
    import aes_inv_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t rk,
    input  logic       first,
    input  logic       last,
    output aes_state_t next_state
);

    aes_state_t unmixed;
    aes_state_t mixed;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi / 4;
            localparam int COL = gi % 4;
            localparam int SRC = 4 * ROW + (COL + 4 - ROW) % 4;
            localparam int R1  = 4 * ((ROW + 1) % 4) + COL;
            localparam int R2  = 4 * ((ROW + 2) % 4) + COL;
            localparam int R3  = 4 * ((ROW + 3) % 4) + COL;

            // Row r is rotated right by r bytes, so byte (r,c) comes from column c-r.
            assign unmixed[8*gi +: 8] = inv_sbox(state[8*SRC +: 8]) ^ rk[8*gi +: 8];

            assign mixed[8*gi +: 8] = gf_mul(8'h0e, unmixed[8*gi +: 8])
                                    ^ gf_mul(8'h0b, unmixed[8*R1 +: 8])
                                    ^ gf_mul(8'h0d, unmixed[8*R2 +: 8])
                                    ^ gf_mul(8'h09, unmixed[8*R3 +: 8]);
        end
    endgenerate

    always_comb begin
        next_state = mixed;
        if (first) begin
            next_state = state ^ rk;
        end else if (last) begin
            next_state = unmixed;
        end
    end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: one inverse round per accepted round key.
// Defining AES_INV_ABORT_EN adds the abort input that cancels a block in RUN or DONE.
module aes_inv_cipher_ctrl
    import aes_inv_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int RK_IDX_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AES_BLK_W-1:0] ct_in,
    output logic                 rk_req,
    output logic [RK_IDX_W-1:0]  rk_idx,
    input  logic                 rk_valid,
    input  logic [AES_BLK_W-1:0] rk_data,
    output logic                 busy,
    output logic                 done,
    output logic [AES_BLK_W-1:0] pt_out
`ifdef AES_INV_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    localparam int                  ROUNDS   = (NUM_ROUNDS > AES_MAX_ROUNDS) ? AES_MAX_ROUNDS
                                                                              : NUM_ROUNDS;
    localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(ROUNDS);

    inv_fsm_e            fsm_q;
    aes_state_t          state_q;
    aes_state_t          pt_q;
    aes_state_t          dp_next;
    logic [RK_IDX_W-1:0] round_q;
    logic                rk_req_q;
    logic                busy_q;
    logic                done_q;
    logic                abort_hit;

`ifdef AES_INV_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    aes_inv_round_dp u_round_dp (
        .state      (state_q),
        .rk         (rk_data),
        .first      (round_q == LAST_IDX),
        .last       (round_q == '0),
        .next_state (dp_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            round_q  <= '0;
            rk_req_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= ct_in;
                        round_q  <= LAST_IDX;
                        rk_req_q <= 1'b1;
                        busy_q   <= 1'b1;
                        fsm_q    <= RUN;
                    end
                end
                RUN: begin
                    // Abort outranks a key delivered in the same cycle.
                    if (abort_hit) begin
                        state_q  <= '0;
                        round_q  <= '0;
                        rk_req_q <= 1'b0;
                        busy_q   <= 1'b0;
                        fsm_q    <= IDLE;
                    end else if (rk_valid) begin
                        if (round_q == '0) begin
                            pt_q     <= dp_next;
                            rk_req_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            fsm_q    <= DONE;
                        end else begin
                            state_q <= dp_next;
                            round_q <= round_q - RK_IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    fsm_q <= IDLE;
                    if (abort_hit) begin
                        state_q <= '0;
                        round_q <= '0;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign rk_req = rk_req_q;
    assign rk_idx = round_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign pt_out = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl (Nr=10 and Nr=14 instances): FIPS-197 vectors, stalls,
// ignored starts, async reset, abort (AES_INV_ABORT_EN) and random blocks from a forward-cipher model.
module tb_aes_inv_cipher_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         start_v    [2];
    logic [127:0] ct_v       [2];
    logic         rk_req_v   [2];
    logic [3:0]   rk_idx_v   [2];
    logic         rk_valid_v [2];
    logic [127:0] rk_data_v  [2];
    logic         busy_v     [2];
    logic         done_v     [2];
    logic [127:0] pt_v       [2];
`ifdef AES_INV_ABORT_EN
    logic         abort_v    [2];
`endif

    logic [127:0] rkm  [2][16];
    logic [7:0]   sbox [256];
    int checks = 0;
    int errors = 0;

    // Key-schedule memory model: answers whatever index is currently requested.
    assign rk_data_v[0] = rkm[0][rk_idx_v[0]];
    assign rk_data_v[1] = rkm[1][rk_idx_v[1]];

    aes_inv_cipher_ctrl #(.NUM_ROUNDS(10), .RK_IDX_W(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .ct_in(ct_v[0]),
        .rk_req(rk_req_v[0]), .rk_idx(rk_idx_v[0]), .rk_valid(rk_valid_v[0]),
        .rk_data(rk_data_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pt_out(pt_v[0])
`ifdef AES_INV_ABORT_EN
        , .abort(abort_v[0])
`endif
    );

    aes_inv_cipher_ctrl #(.NUM_ROUNDS(14), .RK_IDX_W(4)) dut14 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .ct_in(ct_v[1]),
        .rk_req(rk_req_v[1]), .rk_idx(rk_idx_v[1]), .rk_valid(rk_valid_v[1]),
        .rk_data(rk_data_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pt_out(pt_v[1])
`ifdef AES_INV_ABORT_EN
        , .abort(abort_v[1])
`endif
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Forward S-box from the generator-3 walk over GF(2^8).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // FIPS byte stream (in0 in the MSB) to row-major layout: in[k] -> state[k%4][k/4].
    function automatic logic [127:0] to_state(input logic [127:0] f);
        logic [127:0] s;
        for (int k = 0; k < 16; k++) s[8*(4*(k%4) + k/4) +: 8] = f[127-8*k -: 8];
        return s;
    endfunction

    task automatic expand_key(input int w, input logic [255:0] key, input int nk, input int nr);
        logic [31:0]  wd [60];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] v;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    v[8*(4*r+c) +: 8] = wd[4*k+c][31-8*r -: 8];
            rkm[w][k] = v;
        end
    endtask

    // Forward cipher with the same round-key table; the DUT must invert it.
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int w, input int nr);
        logic [127:0] s, t;
        logic [7:0]   a [4];
        s = pt ^ rkm[w][0];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[8*(4*r+c) +: 8] = sbox[s[8*(4*r + (c+r)%4) +: 8]];
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = t[8*(4*r+c) +: 8];
                    for (int r = 0; r < 4; r++)
                        s[8*(4*r+c) +: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4]
                                          ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end else begin
                s = t;
            end
            s = s ^ rkm[w][rnd];
        end
        return s;
    endfunction

    // One block: cut=0 normal, cut=1 async reset at cut_round, cut=2 abort at cut_round.
    task automatic run_block(input int w, input logic [127:0] ct, input int nr,
                             input logic [127:0] exp_pt, input int stall_round,
                             input int stall_len, input bit poke, input int cut,
                             input int cut_round, input logic [127:0] hold_pt);
        int lat, exp_round, stalled;
        @(negedge clk);
        start_v[w]    = 1'b1;
        ct_v[w]       = ct;
        rk_valid_v[w] = 1'b1;
        @(negedge clk);
        start_v[w] = 1'b0;
        ct_v[w]    = {$urandom, $urandom, $urandom, $urandom};
        lat        = 1;
        exp_round  = nr;
        stalled    = 0;
        while (done_v[w] !== 1'b1 && lat < 64) begin
            check_val("rk_req", 128'(rk_req_v[w]), 128'd1);
            check_val("rk_idx", 128'(rk_idx_v[w]), 128'(exp_round));
            check_val("busy", 128'(busy_v[w]), 128'd1);
            if (cut != 0 && exp_round == cut_round) begin
                if (cut == 1) begin
                    rst_n = 1'b0;
                    #1;
                    check_val("rst_rk_req", 128'(rk_req_v[w]), 128'd0);
                    check_val("rst_rk_idx", 128'(rk_idx_v[w]), 128'd0);
                    check_val("rst_busy", 128'(busy_v[w]), 128'd0);
                    check_val("rst_done", 128'(done_v[w]), 128'd0);
                    check_val("rst_pt", pt_v[w], 128'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                end
`ifdef AES_INV_ABORT_EN
                else begin
                    abort_v[w]    = 1'b1;
                    rk_valid_v[w] = 1'b1;
                    @(negedge clk);
                    abort_v[w] = 1'b0;
                    check_val("abort_busy", 128'(busy_v[w]), 128'd0);
                    check_val("abort_rk_req", 128'(rk_req_v[w]), 128'd0);
                    check_val("abort_rk_idx", 128'(rk_idx_v[w]), 128'd0);
                    repeat (4) begin
                        check_val("abort_no_done", 128'(done_v[w]), 128'd0);
                        check_val("abort_pt_hold", pt_v[w], hold_pt);
                        @(negedge clk);
                    end
                end
`endif
                $display("blk dut=%0d nr=%0d cut=%0d at round %0d", w, nr, cut, cut_round);
                return;
            end
            start_v[w] = (poke && lat == 3);
            if (exp_round == stall_round && stalled < stall_len) begin
                rk_valid_v[w] = 1'b0;
                stalled++;
            end else begin
                rk_valid_v[w] = 1'b1;
                if (exp_round > 0) exp_round--;
            end
            @(negedge clk);
            lat++;
        end
        start_v[w]    = 1'b0;
        rk_valid_v[w] = 1'b1;
        check_val("done", 128'(done_v[w]), 128'd1);
        check_val("latency", 128'(lat), 128'(nr + 2 + stall_len));
        check_val("pt", pt_v[w], exp_pt);
        check_val("busy_in_done", 128'(busy_v[w]), 128'd0);
        check_val("rk_req_in_done", 128'(rk_req_v[w]), 128'd0);
        start_v[w] = poke;
        @(negedge clk);
        start_v[w] = 1'b0;
        repeat (2) begin
            check_val("done_pulse", 128'(done_v[w]), 128'd0);
            check_val("busy_after", 128'(busy_v[w]), 128'd0);
            check_val("pt_hold", pt_v[w], exp_pt);
            @(negedge clk);
        end
        $display("blk dut=%0d nr=%0d stall=%0d@%0d poke=%0d lat=%0d pt=%h",
                 w, nr, stall_len, stall_round, poke, lat, pt_v[w]);
    endtask

    initial begin
        logic [127:0] fips_pt, ct1, pt, ct;
        build_sbox();
        rst_n = 1'b0;
        for (int w = 0; w < 2; w++) begin
            start_v[w]    = 1'b0;
            ct_v[w]       = '0;
            rk_valid_v[w] = 1'b0;
`ifdef AES_INV_ABORT_EN
            abort_v[w]    = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        check_val("reset_rk_req", 128'(rk_req_v[0]), 128'd0);
        check_val("reset_rk_idx", 128'(rk_idx_v[0]), 128'd0);
        check_val("reset_busy", 128'(busy_v[0]), 128'd0);
        check_val("reset_done", 128'(done_v[0]), 128'd0);
        check_val("reset_pt", pt_v[0], 128'd0);
        check_val("reset_busy14", 128'(busy_v[1]), 128'd0);
        rst_n = 1'b1;

        fips_pt = to_state(128'h00112233445566778899aabbccddeeff);
        ct1     = to_state(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);

        run_block(0, ct1, 10, fips_pt, -1, 0, 1'b0, 0, 0, '0);
        run_block(0, ct1, 10, fips_pt, 5, 3, 1'b0, 0, 0, '0);
        run_block(0, ct1, 10, fips_pt, -1, 0, 1'b1, 0, 0, '0);
        run_block(0, ct1, 10, fips_pt, -1, 0, 1'b0, 1, 4, '0);
        run_block(0, ct1, 10, fips_pt, -1, 0, 1'b0, 0, 0, '0);
`ifdef AES_INV_ABORT_EN
        run_block(0, ct1, 10, fips_pt, -1, 0, 1'b0, 2, 6, fips_pt);
`endif

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k <= 10; k++)
                rkm[0][k] = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = encrypt(pt, 0, 10);
            run_block(0, ct, 10, pt, int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 0, 0, '0);
        end

        expand_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        run_block(1, to_state(128'h8ea2b7ca516745bfeafc49904b496089), 14, fips_pt,
                  -1, 0, 1'b0, 0, 0, '0);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k <= 14; k++)
                rkm[1][k] = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = encrypt(pt, 1, 14);
            run_block(1, ct, 14, pt, int'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                      1'b1, 0, 0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
